// File: rtl/e1_bram_reader_if.sv
// RAM read port and output stream of the E1 BRAM reader.
// master = reader side (drives the RAM port and the stream), slave = RAM/consumer side.
interface e1_bram_reader_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 6
);
  logic                  en_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] dout_b;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    output en_b, addr_b, m_valid, m_data, m_last,
    input  dout_b, m_ready
  );

  modport slave (
    input  en_b, addr_b, m_valid, m_data, m_last,
    output dout_b, m_ready
  );
endinterface

// File: rtl/e1_bram_reader.sv
// E1 BRAM read-side streaming sequencer: walks a wrapping address range on the
// RAM read port, absorbs the one-cycle read latency and streams words out with
// valid/ready and a last marker.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; the first read is issued on acceptance
// S_RUN   | issuing reads, one per cycle while credit remains
// S_DRAIN | all reads issued, waiting for the last beat to be taken
// S_DONE  | one-cycle completion pulse
module e1_bram_reader #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  e1_bram_reader_if.master      bus
);

  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         issue_cnt_q, issue_cnt_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
  logic                  en_b_q, en_b_d;
  logic                  tag_b_q, tag_b_d;
  logic                  rd_vld_q, rd_vld_d;
  logic                  rd_tag_q, rd_tag_d;

  logic [DATA_WIDTH-1:0] fifo_data_q [4];
  logic [DATA_WIDTH-1:0] fifo_data_d [4];
  logic                  fifo_tag_q  [4];
  logic                  fifo_tag_d  [4];
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [2:0]            occ_q, occ_d;

  logic                  fifo_nempty;
  logic                  push;
  logic                  pop;
  logic [3:0]            commit;
  logic                  credit_ok;

  function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_WIDTH'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  assign fifo_nempty = (occ_q != 3'd0);
  assign push        = rd_vld_q;
  assign pop         = fifo_nempty & bus.m_ready;

  // Reads already committed (queued, at the RAM, or being issued now) minus the
  // beat leaving this cycle; a new read is allowed only if the total stays <= 4,
  // so a freed slot is reused on the very next issue.
  assign commit    = {1'b0, occ_q} + {3'b000, en_b_q} + {3'b000, rd_vld_q} - {3'b000, pop};
  assign credit_ok = (commit < 4'd4);

  // Sequencer next-state and read-issue logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    issue_cnt_d = issue_cnt_q;
    ptr_d       = ptr_q;
    addr_b_d    = addr_b_q;
    en_b_d      = 1'b0;
    tag_b_d     = 1'b0;
    rd_vld_d    = en_b_q;
    rd_tag_d    = tag_b_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count == '0) begin
            state_d = S_DONE;
          end else begin
            cnt_d       = count;
            issue_cnt_d = CW'(1);
            en_b_d      = 1'b1;
            addr_b_d    = base_addr;
            ptr_d       = wrap_inc(base_addr);
            tag_b_d     = (count == CW'(1));
            state_d     = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (issue_cnt_q == cnt_q) begin
          state_d = S_DRAIN;
        end else if (credit_ok) begin
          en_b_d      = 1'b1;
          addr_b_d    = ptr_q;
          ptr_d       = wrap_inc(ptr_q);
          issue_cnt_d = issue_cnt_q + CW'(1);
          tag_b_d     = (issue_cnt_q + CW'(1) == cnt_q);
          if (issue_cnt_q + CW'(1) == cnt_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pop && fifo_tag_q[rd_ptr_q]) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // In-order 4-entry FIFO capturing RAM data the cycle after each read.
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_tag_d  = fifo_tag_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = bus.dout_b;
      fifo_tag_d[wr_ptr_q]  = rd_tag_q;
    end
    wr_ptr_d = wr_ptr_q + {1'b0, push};
    rd_ptr_d = rd_ptr_q + {1'b0, pop};
    occ_d    = occ_q + {2'b00, push} - {2'b00, pop};
  end

  // State, read pipeline and FIFO registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      issue_cnt_q <= '0;
      ptr_q       <= '0;
      addr_b_q    <= '0;
      en_b_q      <= 1'b0;
      tag_b_q     <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_tag_q    <= 1'b0;
      fifo_data_q <= '{default: '0};
      fifo_tag_q  <= '{default: 1'b0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      issue_cnt_q <= issue_cnt_d;
      ptr_q       <= ptr_d;
      addr_b_q    <= addr_b_d;
      en_b_q      <= en_b_d;
      tag_b_q     <= tag_b_d;
      rd_vld_q    <= rd_vld_d;
      rd_tag_q    <= rd_tag_d;
      fifo_data_q <= fifo_data_d;
      fifo_tag_q  <= fifo_tag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
    end
  end

  // Head of FIFO is zeroed when empty so stale entries never show on the stream.
  assign bus.en_b    = en_b_q;
  assign bus.addr_b  = addr_b_q;
  assign bus.m_valid = fifo_nempty;
  assign bus.m_data  = fifo_nempty ? fifo_data_q[rd_ptr_q] : '0;
  assign bus.m_last  = fifo_nempty & fifo_tag_q[rd_ptr_q];
  assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done        = (state_q == S_DONE);

endmodule
